ct_spsram_2048x32_ctrl: RTL and testbench

- Access controller that drives the active-low pin interface of the 2048x32 single-port SRAM: CEN, GWEN, bit-level WEN, A, D, with Q returned one cycle later.
- Presents a valid/ready request channel and a valid/ready read-response channel to LSU-side logic.
- After reset, optionally sweeps the whole array with an init value before accepting traffic.
- Captures Q exactly one cycle after each read and buffers it in a 2-entry response FIFO, so response backpressure never loses data.

---
 rtl/ct_spsram_2048x32_ctrl.sv | 149 ++++++++++++++
 tb/tb_ct_spsram_2048x32_ctrl.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ct_spsram_2048x32_ctrl.sv
// Access controller for a 2048x32 single-port SRAM: optional post-reset init sweep,
// valid/ready request channel and a 2-entry read-response FIFO fed from sram_q.
module ct_spsram_2048x32_ctrl #(
  parameter int                    ADDR_WIDTH = 11,
  parameter int                    DATA_WIDTH = 32,
  parameter bit                    INIT_EN    = 1'b1,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
  input  logic                    forever_cpuclk,
  input  logic                    cpurst,
  input  logic                    req_vld,
  output logic                    req_rdy,
  input  logic                    req_wr,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic [DATA_WIDTH-1:0]   req_wdata,
  input  logic [DATA_WIDTH/8-1:0] req_be,
  output logic                    rsp_vld,
  input  logic                    rsp_rdy,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic                    init_done,
  output logic                    sram_cen,
  output logic                    sram_gwen,
  output logic [DATA_WIDTH-1:0]   sram_wen,
  output logic [ADDR_WIDTH-1:0]   sram_a,
  output logic [DATA_WIDTH-1:0]   sram_d,
  input  logic [DATA_WIDTH-1:0]   sram_q
);

  localparam int                    BE_WIDTH  = DATA_WIDTH / 8;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

  typedef enum logic {
    ST_INIT,
    ST_RUN
  } state_t;

  state_t                  state;
  state_t                  state_nxt;
  logic [ADDR_WIDTH-1:0]   init_cnt;
  logic [ADDR_WIDTH-1:0]   init_cnt_nxt;
  logic                    inflight;
  logic [DATA_WIDTH-1:0]   fifo_mem [2];
  logic                    wr_ptr;
  logic                    rd_ptr;
  logic [1:0]              fifo_cnt;
  logic                    fire;
  logic                    wr_fire;
  logic                    rd_fire;
  logic                    push;
  logic                    pop;
  logic [2:0]              occupancy;
  logic                    rd_credit;

  assign init_done = (state == ST_RUN);

  assign push      = inflight;
  assign pop       = rsp_vld & rsp_rdy;
  assign rsp_vld   = (fifo_cnt != 2'd0);
  assign rsp_rdata = fifo_mem[rd_ptr];

  // A read needs a FIFO slot counting the one already in flight; a same-cycle pop frees one.
  assign occupancy = {1'b0, fifo_cnt} + {2'b00, inflight} - {2'b00, pop};
  assign rd_credit = (occupancy < 3'd2);
  assign req_rdy   = ~cpurst & init_done & (req_wr | rd_credit);

  assign fire    = req_vld & req_rdy;
  assign wr_fire = fire & req_wr;
  assign rd_fire = fire & ~req_wr;

  always_ff @(posedge forever_cpuclk or posedge cpurst) begin
    if (cpurst) begin
      state    <= INIT_EN ? ST_INIT : ST_RUN;
      init_cnt <= '0;
    end else begin
      state    <= state_nxt;
      init_cnt <= init_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    init_cnt_nxt = init_cnt;
    sram_cen     = 1'b1;
    sram_gwen    = 1'b1;
    sram_wen     = '1;
    sram_a       = '0;
    sram_d       = '0;
    case (state)
      ST_INIT: begin
        if (!cpurst) begin
          sram_cen     = 1'b0;
          sram_gwen    = 1'b0;
          sram_wen     = '0;
          sram_a       = init_cnt;
          sram_d       = INIT_VALUE;
          init_cnt_nxt = init_cnt + 1'b1;
          if (init_cnt == LAST_ADDR) begin
            state_nxt = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        if (wr_fire) begin
          sram_cen  = 1'b0;
          sram_gwen = 1'b0;
          sram_a    = req_addr;
          sram_d    = req_wdata;
          for (int i = 0; i < BE_WIDTH; i++) begin
            sram_wen[8*i +: 8] = {8{~req_be[i]}};
          end
        end else if (rd_fire) begin
          sram_cen = 1'b0;
          sram_a   = req_addr;
        end
      end
      default: state_nxt = ST_RUN;
    endcase
  end

  // sram_q is valid the cycle after a read fire, so inflight marks when to capture it.
  always_ff @(posedge forever_cpuclk or posedge cpurst) begin
    if (cpurst) begin
      inflight <= 1'b0;
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
      fifo_cnt <= 2'd0;
    end else begin
      inflight <= rd_fire;
      if (push) begin
        wr_ptr <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 2'd1;
        2'b01:   fifo_cnt <= fifo_cnt - 2'd1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  always_ff @(posedge forever_cpuclk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= sram_q;
    end
  end

endmodule

// File: tb/tb_ct_spsram_2048x32_ctrl.sv
// Directed bench for ct_spsram_2048x32_ctrl: one instance with the init sweep and
// one without, each attached to a behavioural single-port SRAM model.
module tb_ct_spsram_2048x32_ctrl;

  localparam int          AW       = 11;
  localparam logic [31:0] INIT_VAL = 32'hDEADBEEF;

  logic forever_cpuclk = 1'b0;
  always #5 forever_cpuclk = ~forever_cpuclk;

  logic          cpurst;
  logic          req_vld, req_rdy, req_wr;
  logic [AW-1:0] req_addr;
  logic [31:0]   req_wdata;
  logic [3:0]    req_be;
  logic          rsp_vld, rsp_rdy;
  logic [31:0]   rsp_rdata;
  logic          init_done;
  logic          sram_cen, sram_gwen;
  logic [31:0]   sram_wen, sram_d, sram_q;
  logic [AW-1:0] sram_a;

  logic          rst_b;
  logic          req_vld_b, req_rdy_b, req_wr_b;
  logic [3:0]    req_addr_b;
  logic [31:0]   req_wdata_b;
  logic [3:0]    req_be_b;
  logic          rsp_vld_b, rsp_rdy_b;
  logic [31:0]   rsp_rdata_b;
  logic          init_done_b;
  logic          sram_cen_b, sram_gwen_b;
  logic [31:0]   sram_wen_b, sram_d_b, sram_q_b;
  logic [3:0]    sram_a_b;

  logic [31:0] mem   [0:(1<<AW)-1];
  logic [31:0] mem_b [0:15];

  int checkCount = 0;
  int errorCount = 0;

  ct_spsram_2048x32_ctrl #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(32), .INIT_EN(1'b1), .INIT_VALUE(INIT_VAL)
  ) dut (
    .forever_cpuclk(forever_cpuclk), .cpurst(cpurst),
    .req_vld(req_vld), .req_rdy(req_rdy), .req_wr(req_wr), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_be(req_be),
    .rsp_vld(rsp_vld), .rsp_rdy(rsp_rdy), .rsp_rdata(rsp_rdata), .init_done(init_done),
    .sram_cen(sram_cen), .sram_gwen(sram_gwen), .sram_wen(sram_wen),
    .sram_a(sram_a), .sram_d(sram_d), .sram_q(sram_q)
  );

  ct_spsram_2048x32_ctrl #(
    .ADDR_WIDTH(4), .DATA_WIDTH(32), .INIT_EN(1'b0), .INIT_VALUE(32'h0)
  ) dut_noinit (
    .forever_cpuclk(forever_cpuclk), .cpurst(rst_b),
    .req_vld(req_vld_b), .req_rdy(req_rdy_b), .req_wr(req_wr_b), .req_addr(req_addr_b),
    .req_wdata(req_wdata_b), .req_be(req_be_b),
    .rsp_vld(rsp_vld_b), .rsp_rdy(rsp_rdy_b), .rsp_rdata(rsp_rdata_b), .init_done(init_done_b),
    .sram_cen(sram_cen_b), .sram_gwen(sram_gwen_b), .sram_wen(sram_wen_b),
    .sram_a(sram_a_b), .sram_d(sram_d_b), .sram_q(sram_q_b)
  );

  // Behavioural SRAM: bit-masked write when gwen is low, registered read otherwise.
  always @(posedge forever_cpuclk) begin
    if (!sram_cen) begin
      if (!sram_gwen) mem[sram_a] <= (mem[sram_a] & sram_wen) | (sram_d & ~sram_wen);
      else            sram_q      <= mem[sram_a];
    end
    if (!sram_cen_b) begin
      if (!sram_gwen_b) mem_b[sram_a_b] <= (mem_b[sram_a_b] & sram_wen_b) | (sram_d_b & ~sram_wen_b);
      else              sram_q_b        <= mem_b[sram_a_b];
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: observed %h, expected %h", tag, observed, expected);
    end
  endtask

  task automatic tick;
    @(posedge forever_cpuclk);
    #1;
  endtask

  task automatic applyStimulus(input logic vld, input logic wr, input logic [AW-1:0] addr,
                               input logic [31:0] wdata, input logic [3:0] be, input logic rsprdy);
    req_vld   = vld;
    req_wr    = wr;
    req_addr  = addr;
    req_wdata = wdata;
    req_be    = be;
    rsp_rdy   = rsprdy;
    #1;
  endtask

  task automatic sweepCheck(input string tag);
    int bad = 0;
    for (int i = 0; i < (1 << AW); i++) begin
      if (sram_cen !== 1'b0 || sram_gwen !== 1'b0 || sram_wen !== 32'h0 ||
          sram_a !== i[AW-1:0] || sram_d !== INIT_VAL || req_rdy !== 1'b0 || init_done !== 1'b0)
        bad++;
      tick();
    end
    checkOutput({tag, "_bad_cycles"}, bad, 0);
    applyStimulus(1'b0, 1'b0, '0, 32'h0, 4'h0, 1'b1);
    checkOutput({tag, "_init_done"}, init_done, 1);
    checkOutput({tag, "_cen_idle"}, sram_cen, 1);
  endtask

  task automatic writeReq(input logic [AW-1:0] addr, input logic [31:0] data, input logic [3:0] be);
    applyStimulus(1'b1, 1'b1, addr, data, be, 1'b1);
    checkOutput("wr_rdy", req_rdy, 1);
    tick();
  endtask

  task automatic readCheck(input logic [AW-1:0] addr, input logic [31:0] expected, input string tag);
    applyStimulus(1'b1, 1'b0, addr, 32'h0, 4'h0, 1'b1);
    checkOutput({tag, "_rdy"}, req_rdy, 1);
    tick();
    applyStimulus(1'b0, 1'b0, '0, 32'h0, 4'h0, 1'b1);
    checkOutput({tag, "_vld_early"}, rsp_vld, 0);
    tick();
    checkOutput({tag, "_vld"}, rsp_vld, 1);
    checkOutput({tag, "_data"}, rsp_rdata, expected);
    tick();
    checkOutput({tag, "_vld_after"}, rsp_vld, 0);
  endtask

  logic bpRdy [5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};

  initial begin
    cpurst = 1'b1;
    rst_b  = 1'b1;
    req_vld_b = 1'b0; req_wr_b = 1'b0; req_addr_b = '0; req_wdata_b = '0; req_be_b = '0; rsp_rdy_b = 1'b1;
    applyStimulus(1'b1, 1'b1, 11'd5, 32'h12345678, 4'hF, 1'b1);
    repeat (3) tick();

    checkOutput("rst_init_done", init_done, 0);
    checkOutput("rst_rsp_vld", rsp_vld, 0);
    checkOutput("rst_req_rdy", req_rdy, 0);
    checkOutput("rst_cen", sram_cen, 1);
    checkOutput("rst_gwen", sram_gwen, 1);
    checkOutput("rst_wen", sram_wen, 32'hFFFFFFFF);
    checkOutput("rst_a", sram_a, 0);
    checkOutput("rst_d", sram_d, 0);

    cpurst = 1'b0;
    #1;
    sweepCheck("sweep1");

    readCheck(11'd0, INIT_VAL, "init_rd0");
    readCheck(11'd1023, INIT_VAL, "init_rd1023");
    readCheck(11'd2047, INIT_VAL, "init_rd2047");

    writeReq(11'd5, 32'h11223344, 4'hF);
    applyStimulus(1'b1, 1'b1, 11'd5, 32'hAABBCCDD, 4'b0101, 1'b1);
    checkOutput("mask_wen", sram_wen, 32'hFF00FF00);
    checkOutput("mask_gwen", sram_gwen, 0);
    checkOutput("mask_cen", sram_cen, 0);
    checkOutput("mask_a", sram_a, 5);
    tick();
    readCheck(11'd5, 32'h11BB33DD, "mask_rd5");

    for (int i = 0; i < 8; i++) writeReq(i[AW-1:0], 32'h10000000 + i, 4'hF);

    for (int k = 0; k < 10; k++) begin
      if (k < 8) applyStimulus(1'b1, 1'b0, k[AW-1:0], 32'h0, 4'h0, 1'b1);
      else       applyStimulus(1'b0, 1'b0, '0, 32'h0, 4'h0, 1'b1);
      if (k < 8) checkOutput("b2b_rdy", req_rdy, 1);
      if (k >= 2) begin
        checkOutput("b2b_vld", rsp_vld, 1);
        checkOutput("b2b_data", rsp_rdata, 32'h10000000 + k - 2);
      end else begin
        checkOutput("b2b_vld_early", rsp_vld, 0);
      end
      tick();
    end
    checkOutput("b2b_vld_end", rsp_vld, 0);

    for (int k = 0; k < 5; k++) begin
      applyStimulus(1'b1, 1'b0, 11'd2 + k[AW-1:0], 32'h0, 4'h0, 1'b0);
      checkOutput("bp_rdy", req_rdy, {31'h0, bpRdy[k]});
      tick();
    end
    checkOutput("bp_vld_stall", rsp_vld, 1);
    checkOutput("bp_data_stall", rsp_rdata, 32'h10000002);
    applyStimulus(1'b1, 1'b1, 11'd8, 32'h88888888, 4'hF, 1'b0);
    checkOutput("bp_wr_rdy", req_rdy, 1);
    tick();
    applyStimulus(1'b1, 1'b0, 11'd9, 32'h0, 4'h0, 1'b0);
    checkOutput("bp_rd_blocked", req_rdy, 0);
    applyStimulus(1'b0, 1'b0, '0, 32'h0, 4'h0, 1'b1);
    checkOutput("drain_vld0", rsp_vld, 1);
    checkOutput("drain_data0", rsp_rdata, 32'h10000002);
    tick();
    checkOutput("drain_vld1", rsp_vld, 1);
    checkOutput("drain_data1", rsp_rdata, 32'h10000003);
    tick();
    checkOutput("drain_empty", rsp_vld, 0);
    readCheck(11'd8, 32'h88888888, "resume_rd8");

    applyStimulus(1'b1, 1'b0, 11'd0, 32'h0, 4'h0, 1'b0);
    tick();
    applyStimulus(1'b1, 1'b0, 11'd1, 32'h0, 4'h0, 1'b0);
    tick();
    checkOutput("pre_rst_vld", rsp_vld, 1);
    cpurst = 1'b1;
    #1;
    checkOutput("midrst_vld", rsp_vld, 0);
    checkOutput("midrst_cen", sram_cen, 1);
    checkOutput("midrst_init_done", init_done, 0);
    checkOutput("midrst_rdy", req_rdy, 0);
    tick();
    tick();
    cpurst = 1'b0;
    applyStimulus(1'b1, 1'b1, 11'd8, 32'h55555555, 4'hF, 1'b1);
    sweepCheck("sweep2");
    checkOutput("post_rst_vld", rsp_vld, 0);
    readCheck(11'd8, INIT_VAL, "post_rst_rd8");

    req_vld_b = 1'b1; req_wr_b = 1'b1; req_addr_b = 4'd3; req_wdata_b = 32'hCAFEF00D; req_be_b = 4'hF;
    #1;
    checkOutput("noinit_rst_done", init_done_b, 1);
    checkOutput("noinit_rst_rdy", req_rdy_b, 0);
    checkOutput("noinit_rst_cen", sram_cen_b, 1);
    tick();
    rst_b = 1'b0;
    #1;
    checkOutput("noinit_first_rdy", req_rdy_b, 1);
    checkOutput("noinit_first_cen", sram_cen_b, 0);
    checkOutput("noinit_first_gwen", sram_gwen_b, 0);
    tick();
    req_wr_b = 1'b0;
    #1;
    checkOutput("noinit_rd_rdy", req_rdy_b, 1);
    tick();
    req_vld_b = 1'b0;
    tick();
    checkOutput("noinit_rsp_vld", rsp_vld_b, 1);
    checkOutput("noinit_rsp_data", rsp_rdata_b, 32'hCAFEF00D);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
